// File: rtl/matrix_pixel_fetch.sv
`default_nettype none
// ============================================================================
// matrix_pixel_fetch : framebuffer read addressing, bit-plane slicing and
//                      frame-synchronous double-buffer swap for LED matrices
// Revision: 1.0
// ============================================================================
module matrix_pixel_fetch #(
  parameter int COL_BITS = 6,
  parameter int ROW_BITS = 4,
  parameter int BPC      = 6
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic [7:0]                   column_address,
  input  logic [ROW_BITS-1:0]          row_address,
  input  logic [BPC-1:0]               brightness_mask,
  input  logic                         pixel_en,
  output logic [ROW_BITS+COL_BITS+1:0] ram_addr_top,
  output logic [ROW_BITS+COL_BITS+1:0] ram_addr_bot,
  input  logic [3*BPC-1:0]             ram_data_top,
  input  logic [3*BPC-1:0]             ram_data_bot,
  output logic [2:0]                   rgb_top,
  output logic [2:0]                   rgb_bot,
  output logic                         rgb_valid,
  input  logic                         swap_request,
  output logic                         swap_ack,
  output logic                         display_buffer
);

  localparam int ADDR_W = 2 + ROW_BITS + COL_BITS;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PENDING = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [ADDR_W-1:0]   ram_addr_top_q, ram_addr_top_d;
  logic [ADDR_W-1:0]   ram_addr_bot_q, ram_addr_bot_d;
  logic [BPC-1:0]      mask_d1_q, mask_d1_d;
  logic [BPC-1:0]      mask_d2_q, mask_d2_d;
  logic                en_d1_q, en_d1_d;
  logic                en_d2_q, en_d2_d;
  logic [2:0]          rgb_top_q, rgb_top_d;
  logic [2:0]          rgb_bot_q, rgb_bot_d;
  logic                rgb_valid_q, rgb_valid_d;
  logic                swap_ack_q, swap_ack_d;
  logic                display_buffer_q, display_buffer_d;
  logic [ROW_BITS-1:0] prev_row_q, prev_row_d;

  logic                boundary;
  logic                swap_fire;
  logic [2:0]          hit_top;
  logic [2:0]          hit_bot;

  // Upper column bits come from a wider scan counter and are not needed here.
  generate
    if (COL_BITS < 8) begin : g_col_unused
      logic unused_col_bits;
      assign unused_col_bits = ^column_address[7:COL_BITS];
    end
  endgenerate

  // Channel c of the {R,G,B} word lives at bits [c*BPC +: BPC]; rgb bit c matches.
  generate
    for (genvar c = 0; c < 3; c++) begin : g_chan
      assign hit_top[c] = |(ram_data_top[c*BPC +: BPC] & mask_d2_q);
      assign hit_bot[c] = |(ram_data_bot[c*BPC +: BPC] & mask_d2_q);
    end
  endgenerate

  assign boundary = (prev_row_q == {ROW_BITS{1'b1}}) && (row_address == '0);

  // State and pipeline registers
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      ram_addr_top_q   <= '0;
      ram_addr_bot_q   <= '0;
      mask_d1_q        <= '0;
      mask_d2_q        <= '0;
      en_d1_q          <= 1'b0;
      en_d2_q          <= 1'b0;
      rgb_top_q        <= 3'b000;
      rgb_bot_q        <= 3'b000;
      rgb_valid_q      <= 1'b0;
      swap_ack_q       <= 1'b0;
      display_buffer_q <= 1'b0;
      prev_row_q       <= '0;
    end else begin
      state_q          <= state_d;
      ram_addr_top_q   <= ram_addr_top_d;
      ram_addr_bot_q   <= ram_addr_bot_d;
      mask_d1_q        <= mask_d1_d;
      mask_d2_q        <= mask_d2_d;
      en_d1_q          <= en_d1_d;
      en_d2_q          <= en_d2_d;
      rgb_top_q        <= rgb_top_d;
      rgb_bot_q        <= rgb_bot_d;
      rgb_valid_q      <= rgb_valid_d;
      swap_ack_q       <= swap_ack_d;
      display_buffer_q <= display_buffer_d;
      prev_row_q       <= prev_row_d;
    end
  end

  // Swap FSM next-state; a request arriving on a boundary never parks in PENDING.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (swap_request && !boundary) begin
          state_d = S_PENDING;
        end
      end
      S_PENDING: begin
        if (boundary) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Swap FSM output decode
  always_comb begin
    swap_fire = 1'b0;
    case (state_q)
      S_IDLE:    swap_fire = boundary && swap_request;
      S_PENDING: swap_fire = boundary;
      default:   swap_fire = 1'b0;
    endcase
  end

  // Datapath; addresses use the pre-flip buffer so the flip shows on the next address.
  always_comb begin
    ram_addr_top_d   = {display_buffer_q, 1'b0, row_address, column_address[COL_BITS-1:0]};
    ram_addr_bot_d   = {display_buffer_q, 1'b1, row_address, column_address[COL_BITS-1:0]};
    mask_d1_d        = brightness_mask;
    mask_d2_d        = mask_d1_q;
    en_d1_d          = pixel_en;
    en_d2_d          = en_d1_q;
    rgb_top_d        = en_d2_q ? hit_top : 3'b000;
    rgb_bot_d        = en_d2_q ? hit_bot : 3'b000;
    rgb_valid_d      = en_d2_q;
    prev_row_d       = row_address;
    display_buffer_d = display_buffer_q ^ swap_fire;
    swap_ack_d       = swap_fire;
  end

  assign ram_addr_top   = ram_addr_top_q;
  assign ram_addr_bot   = ram_addr_bot_q;
  assign rgb_top        = rgb_top_q;
  assign rgb_bot        = rgb_bot_q;
  assign rgb_valid      = rgb_valid_q;
  assign swap_ack       = swap_ack_q;
  assign display_buffer = display_buffer_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_pixel_fetch.sv
`default_nettype none
// ============================================================================
// tb_matrix_pixel_fetch : vector table, swap corner sequences and randomized
//                         traffic against a frame-level reference model
// Revision: 1.0
// ============================================================================
module tb_matrix_pixel_fetch;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b0;
  logic [7:0]  column_address = '0;
  logic [3:0]  row_address = '0;
  logic [5:0]  brightness_mask = '0;
  logic        pixel_en = 1'b0;
  logic [11:0] ram_addr_top, ram_addr_bot;
  logic [17:0] ram_data_top = '0, ram_data_bot = '0;
  logic [2:0]  rgb_top, rgb_bot;
  logic        rgb_valid;
  logic        swap_request = 1'b0;
  logic        swap_ack;
  logic        display_buffer;

  matrix_pixel_fetch #(.COL_BITS(6), .ROW_BITS(4), .BPC(6)) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .column_address(column_address),
    .row_address   (row_address),
    .brightness_mask(brightness_mask),
    .pixel_en      (pixel_en),
    .ram_addr_top  (ram_addr_top),
    .ram_addr_bot  (ram_addr_bot),
    .ram_data_top  (ram_data_top),
    .ram_data_bot  (ram_data_bot),
    .rgb_top       (rgb_top),
    .rgb_bot       (rgb_bot),
    .rgb_valid     (rgb_valid),
    .swap_request  (swap_request),
    .swap_ack      (swap_ack),
    .display_buffer(display_buffer)
  );

  always #5 clk_in = ~clk_in;

  // Framebuffer RAM with one cycle of read latency
  logic [17:0] mem [4096];
  always @(posedge clk_in) begin
    ram_data_top <= mem[ram_addr_top];
    ram_data_bot <= mem[ram_addr_bot];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what the panel should see, per sampled input cycle
  typedef struct {
    logic        en;
    logic [5:0]  mask;
    logic [11:0] at;
    logic [11:0] ab;
  } rec_t;

  rec_t       pend_q[$];
  logic       m_buf, m_pend;
  logic [3:0] m_prev;
  rec_t       zero_rec;

  function automatic logic [2:0] plane(input logic [17:0] w, input logic [5:0] m);
    logic [2:0] r;
    for (int c = 0; c < 3; c++) r[c] = ((w[c*6 +: 6] & m) != 6'd0);
    return r;
  endfunction

  task automatic model_reset();
    zero_rec = '{en: 1'b0, mask: 6'd0, at: 12'd0, ab: 12'd0};
    pend_q.delete();
    pend_q.push_back(zero_rec);
    pend_q.push_back(zero_rec);
    m_buf  = 1'b0;
    m_pend = 1'b0;
    m_prev = 4'd0;
  endtask

  // Drive one cycle of inputs, advance past the edge and compare everything.
  task automatic tick(input logic [7:0] col, input logic [3:0] row, input logic [5:0] mask,
                      input logic en, input logic swp);
    rec_t r, old;
    logic bnd, fire;
    logic [2:0] et, eb;
    column_address  = col;
    row_address     = row;
    brightness_mask = mask;
    pixel_en        = en;
    swap_request    = swp;
    @(posedge clk_in);
    #1;
    bnd  = (m_prev == 4'hF) && (row == 4'd0);
    fire = bnd && (m_pend || swp);
    r.en = en; r.mask = mask;
    r.at = {m_buf, 1'b0, row, col[5:0]};
    r.ab = {m_buf, 1'b1, row, col[5:0]};
    pend_q.push_back(r);
    old = pend_q.pop_front();
    m_pend = fire ? 1'b0 : (m_pend || swp);
    m_buf  = m_buf ^ fire;
    m_prev = row;
    et = old.en ? plane(mem[old.at], old.mask) : 3'b000;
    eb = old.en ? plane(mem[old.ab], old.mask) : 3'b000;
    chk("addr", {ram_addr_top, ram_addr_bot}, {r.at, r.ab});
    chk("rgb",  {rgb_valid, rgb_top, rgb_bot}, {old.en, et, eb});
    chk("swap", {swap_ack, display_buffer}, {fire, m_buf});
    swap_request = 1'b0;
  endtask

  task automatic all_zero(input string name);
    chk(name, {ram_addr_top, ram_addr_bot, rgb_top, rgb_bot, rgb_valid, swap_ack, display_buffer}, 64'd0);
  endtask

  // Assert reset between edges with busy inputs, hold across an edge, release on negedge.
  task automatic do_reset();
    column_address = 8'h2A; row_address = 4'd9; brightness_mask = 6'h3F; pixel_en = 1'b1;
    reset = 1'b0;
    #1 all_zero("reset_async");
    @(posedge clk_in); #1 all_zero("reset_held");
    @(negedge clk_in); reset = 1'b1;
    #1 all_zero("reset_release_edge");
    model_reset();
  endtask

  typedef struct {
    logic [7:0]  col;
    logic [3:0]  row;
    logic [5:0]  mask;
    logic        en;
    logic [17:0] dtop;
    logic [17:0] dbot;
    logic [11:0] exp_at;
    logic [11:0] exp_ab;
    logic [2:0]  exp_top;
    logic [2:0]  exp_bot;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[5];
  int   acks;
  logic [3:0] rw;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 18'($urandom);
    vecs[0] = '{8'd5,   4'd3,  6'b100000, 1'b1, {6'h20,6'h01,6'h00}, {6'h3F,6'h00,6'h3F}, 12'h0C5, 12'h4C5, 3'b100, 3'b101, 1'b1};
    vecs[1] = '{8'd63,  4'd15, 6'b000001, 1'b1, {6'h01,6'h01,6'h01}, {6'h3E,6'h3E,6'h3E}, 12'h3FF, 12'h7FF, 3'b111, 3'b000, 1'b1};
    vecs[2] = '{8'd0,   4'd0,  6'b000000, 1'b1, {6'h3F,6'h3F,6'h3F}, {6'h3F,6'h3F,6'h3F}, 12'h000, 12'h400, 3'b000, 3'b000, 1'b1};
    vecs[3] = '{8'h8A,  4'd9,  6'b000011, 1'b1, {6'h02,6'h04,6'h01}, {6'h00,6'h03,6'h00}, 12'h24A, 12'h64A, 3'b101, 3'b010, 1'b1};
    vecs[4] = '{8'd33,  4'd1,  6'b111111, 1'b0, {6'h3F,6'h3F,6'h3F}, {6'h3F,6'h3F,6'h3F}, 12'h061, 12'h461, 3'b000, 3'b000, 1'b0};

    model_reset();
    #2;
    do_reset();

    // Vector table: address after one edge, pixel after three
    for (int v = 0; v < 5; v++) begin
      mem[vecs[v].exp_at] = vecs[v].dtop;
      mem[vecs[v].exp_ab] = vecs[v].dbot;
      tick(vecs[v].col, vecs[v].row, vecs[v].mask, vecs[v].en, 1'b0);
      chk($sformatf("vec%0d_addr", v), {ram_addr_top, ram_addr_bot}, {vecs[v].exp_at, vecs[v].exp_ab});
      chk($sformatf("vec%0d_early", v), rgb_valid, 1'b0);
      tick(vecs[v].col, vecs[v].row, 6'd0, 1'b0, 1'b0);
      tick(vecs[v].col, vecs[v].row, 6'd0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_rgb", v), {rgb_valid, rgb_top, rgb_bot},
          {vecs[v].exp_valid, vecs[v].exp_top, vecs[v].exp_bot});
    end
    chk("idle_boundary_no_swap", display_buffer, 1'b0);

    // Swap requested mid-frame, taken at the 15->0 wrap
    acks = 0;
    tick(8'd1, 4'd7, 6'd1, 1'b1, 1'b1);
    acks += swap_ack;
    for (int r = 8; r <= 15; r++) begin
      tick(8'd1, 4'(r), 6'd1, 1'b1, 1'b0);
      acks += swap_ack;
    end
    chk("pend_no_early_ack", acks, 0);
    tick(8'd1, 4'd0, 6'd1, 1'b1, 1'b0);
    chk("wrap_ack", {swap_ack, display_buffer}, 2'b11);
    tick(8'd2, 4'd0, 6'd1, 1'b1, 1'b0);
    chk("ack_single", swap_ack, 1'b0);
    chk("addr_buf1", ram_addr_top[11], 1'b1);

    // Two requests before one boundary
    acks = 0;
    for (int r = 1; r <= 15; r++) begin
      tick(8'd3, 4'(r), 6'd2, 1'b1, (r == 2 || r == 4));
      acks += swap_ack;
    end
    tick(8'd3, 4'd0, 6'd2, 1'b1, 1'b0);
    acks += swap_ack;
    for (int k = 0; k < 3; k++) begin
      tick(8'd3, 4'd1, 6'd2, 1'b1, 1'b0);
      acks += swap_ack;
    end
    chk("double_req_one_ack", acks, 1);
    chk("double_req_buf", display_buffer, 1'b0);

    // Request on the boundary cycle itself
    tick(8'd4, 4'd15, 6'd4, 1'b1, 1'b0);
    tick(8'd4, 4'd0, 6'd4, 1'b1, 1'b1);
    chk("same_cycle_ack", {swap_ack, display_buffer}, 2'b11);

    // Reset while PENDING discards the swap
    tick(8'd5, 4'd5, 6'd8, 1'b1, 1'b1);
    do_reset();
    acks = 0;
    for (int r = 6; r <= 15; r++) begin
      tick(8'd5, 4'(r), 6'd8, 1'b1, 1'b0);
      acks += swap_ack;
    end
    tick(8'd5, 4'd0, 6'd8, 1'b1, 1'b0);
    acks += swap_ack;
    chk("reset_pend_no_ack", acks, 0);
    chk("reset_pend_buf", display_buffer, 1'b0);

    // Randomized traffic with one asynchronous reset in the middle
    rw = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2;
        do_reset();
      end
      if (i % 4 == 0) rw = rw + 4'd1;
      tick(8'($urandom), rw,
           ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_pixel_fetch.md
MATRIX_PIXEL_FETCH -- requirements
Module: matrix_pixel_fetch

Interface
REQ-001 Parameter COL_BITS, default 6, gives the column address bits used (64 columns).
REQ-002 Parameter ROW_BITS, default 4, gives the row address bits used (16 scan rows per half-panel).
REQ-003 Parameter BPC, default 6, gives the brightness bits per colour channel; it SHALL equal the brightness_mask width.
REQ-004 Port clk_in, input, 1 bit: the single clock. All logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port column_address, input, 8 bits: the current column from the scan stage. Only bits [COL_BITS-1:0] are used.
REQ-007 Port row_address, input, ROW_BITS bits: the current scan row.
REQ-008 Port brightness_mask, input, BPC bits: one-hot bit-plane select.
REQ-009 Port pixel_en, input, 1 bit: the scan stage is shifting pixels this cycle.
REQ-010 Port ram_addr_top and port ram_addr_bot, outputs, 1+1+ROW_BITS+COL_BITS bits each: framebuffer read addresses.
REQ-011 Port ram_data_top and port ram_data_bot, inputs, 3*BPC bits each: {R,G,B} pixel words, valid 1 cycle after the address.
REQ-012 Port rgb_top and port rgb_bot, outputs, 3 bits each: {R,G,B} serial data to the panel.
REQ-013 Port rgb_valid, output, 1 bit: rgb_top/rgb_bot carry a pixel.
REQ-014 Port swap_request, input, 1 bit: single-cycle pulse asking to flip the display buffer.
REQ-015 Port swap_ack, output, 1 bit: single-cycle pulse on the cycle the buffer flips.
REQ-016 Port display_buffer, output, 1 bit: the buffer currently being displayed.

Function
REQ-017 ram_addr_top SHALL be {display_buffer, 1'b0, row_address, column_address[COL_BITS-1:0]}, registered (1 cycle).
REQ-018 ram_addr_bot SHALL be {display_buffer, 1'b1, row_address, column_address[COL_BITS-1:0]}, registered.
REQ-019 brightness_mask and pixel_en SHALL be delayed 2 cycles (mask_d2, en_d2) to align with the RAM data.
REQ-020 rgb_top[c] SHALL be the registered OR-reduction of (channel c of ram_data_top AND mask_d2); rgb_bot likewise.
REQ-021 Total latency from column_address/pixel_en to rgb outputs SHALL be 3 cycles. rgb_valid SHALL be en_d2, registered.
REQ-022 When en_d2=0, rgb_top and rgb_bot SHALL be driven 3'b000.
REQ-023 A mask of zero or non-one-hot value SHALL yield OR-of-AND results as defined, with no special-casing; mask 0 gives black.
REQ-024 A frame boundary SHALL be the cycle on which the registered previous row equals all-ones and row_address equals 0.
REQ-025 The swap FSM SHALL have two states: IDLE and PENDING.
- IDLE --swap_request--> PENDING.
- PENDING --boundary--> IDLE: display_buffer toggles, swap_ack=1 for that cycle only.
REQ-026 If swap_request and a boundary coincide in IDLE, the swap SHALL occur on that same cycle.
REQ-027 A swap_request while PENDING SHALL be ignored (no queueing, no second ack).
REQ-028 The buffer flip SHALL affect ram_addr from the next registered address onward. In-flight pipeline data SHALL complete unchanged.
REQ-029 A boundary in IDLE SHALL have no effect.

Reset
REQ-030 When reset=0, all registers SHALL clear asynchronously: addresses 0, rgb_top/rgb_bot 0, rgb_valid 0, swap_ack 0, display_buffer 0, FSM IDLE, previous-row register 0, delay pipes 0.
REQ-031 Reset asserted mid-frame or while PENDING SHALL discard the pending swap. The first rgb_valid after release SHALL occur no earlier than 3 cycles after the first pixel_en=1.
REQ-032 Outputs SHALL not change on the deassertion edge. The first update SHALL be on the following rising clk_in edge.

Verification
REQ-033 Bench shall apply column 5, row 3, buffer 0 -> ram_addr_top=0x0C5 and ram_addr_bot=0x4C5, one cycle later.
REQ-034 Bench shall apply ram_data_top={R=6'h20,G=6'h01,B=6'h00}, mask 6'b100000, pixel_en=1 -> rgb_top=3'b100 and rgb_valid=1, 3 cycles after input.
REQ-035 Bench shall apply a swap_request pulse at row 7, then step rows to 15, then 0 -> swap_ack is a single pulse on the 15->0 cycle, display_buffer=1, and the next ram_addr has bit 11 set.
REQ-036 Bench shall apply two swap_requests before one boundary -> exactly one swap_ack, and display_buffer toggles once.
REQ-037 Bench shall apply swap_request on the boundary cycle -> swap_ack on that cycle.
REQ-038 Bench shall assert reset while PENDING, then release it and cross a boundary -> no swap_ack, display_buffer=0, and all outputs 0 during reset.
